// File: rtl/ecg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ecg_pkg                                                         |
// | Purpose  : Shared constants and types for the ECG sample sequencer slice.  |
// |            Frame depth, sample/address widths, sequencer state encoding    |
// |            and the beat record carried through the output FIFO.            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package ecg_pkg;

  localparam int N_SAMPLES = 187;  // frame depth (ROM entries)
  localparam int DATA_W    = 32;   // float32 bit pattern, passed through untouched
  localparam int ADDR_W    = 8;    // ROM address / sample index width

  typedef logic [DATA_W-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } seq_state_t;

  typedef struct packed {
    sample_t           data;
    logic [ADDR_W-1:0] index;
    logic              last;
  } beat_t;

endpackage
`default_nettype wire

// File: rtl/ecg_sample_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ecg_sample_sequencer_if                                         |
// | Purpose  : valid/ready sample stream from the sequencer to the first       |
// |            convolution stage.                                              |
// | Ports    : m_valid, m_ready, m_data (sample), m_index (ROM address of the  |
// |            sample), m_last (final beat of frame).                          |
// |            master = sequencer side, slave = consumer side.                 |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface ecg_sample_sequencer_if;
  import ecg_pkg::*;

  logic              m_valid;
  logic              m_ready;
  sample_t           m_data;
  logic [ADDR_W-1:0] m_index;
  logic              m_last;

  modport master (output m_valid, m_data, m_index, m_last, input  m_ready);
  modport slave  (input  m_valid, m_data, m_index, m_last, output m_ready);

endinterface
`default_nettype wire

// File: rtl/ecg_stream_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ecg_stream_fifo                                                 |
// | Purpose  : 2-entry FIFO of beat records between the ROM return path and    |
// |            the output stream.                                              |
// | Ports    : clk, rst_n (async, active-low), flush (empties the FIFO, wins   |
// |            over push/pop), push/wr_beat, pop, rd_beat (head entry),        |
// |            count (entries held, 0..2).                                     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module ecg_stream_fifo
  import ecg_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       push,
  input  beat_t      wr_beat,
  input  logic       pop,
  output beat_t      rd_beat,
  output logic [1:0] count
);

  beat_t      r_mem [2];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;

  // Caller never pushes when full or pops when empty (credit-controlled).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (push) begin
        r_mem[r_wr_ptr] <= wr_beat;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({push, pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign rd_beat = r_mem[r_rd_ptr];
  assign count   = r_count;

endmodule
`default_nettype wire

// File: rtl/ecg_sample_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ecg_sample_sequencer                                            |
// | Purpose  : Streams one ECG frame from the synchronous sample ROM onto a    |
// |            valid/ready stream with index and last-beat tagging.            |
// | Ports    : clk, rst_n (async, active-low)                                  |
// |            start/len (frame request, len 0 or >N_SAMPLES = full frame),    |
// |            abort (terminate current frame)                                 |
// |            rom_en/rom_addr -> ROM, rom_data <- ROM (1-cycle latency)       |
// |            m_if (master stream), busy, done (1-cycle pulse),               |
// |            frame_cnt (completed non-aborted frames, wrapping)              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module ecg_sample_sequencer
  import ecg_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [ADDR_W-1:0]             len,
  input  logic                          abort,
  output logic                          rom_en,
  output logic [ADDR_W-1:0]             rom_addr,
  input  sample_t                       rom_data,
  ecg_sample_sequencer_if.master        m_if,
  output logic                          busy,
  output logic                          done,
  output logic [15:0]                   frame_cnt
);

  localparam logic [ADDR_W-1:0] c_n_samples = ADDR_W'(N_SAMPLES);

  seq_state_t        r_state;
  seq_state_t        w_next_state;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W-1:0] r_len_m1;
  logic              r_if_valid;   // a ROM read is returning this cycle
  logic [ADDR_W-1:0] r_if_idx;
  logic              r_if_last;
  logic              r_done;
  logic [15:0]       r_frame_cnt;

  logic [ADDR_W-1:0] w_len_eff;
  logic              w_start_go;
  logic              w_abort_go;
  logic [1:0]        w_fifo_count;
  logic [1:0]        w_used;
  logic              w_fifo_empty;
  beat_t             w_head;
  beat_t             w_rom_beat;
  beat_t             w_out_beat;
  logic              w_out_valid;
  logic              w_xfer;
  logic              w_push;
  logic              w_pop;
  logic              w_last_xfer;

  assign w_len_eff  = ((len == '0) || (len > c_n_samples)) ? c_n_samples : len;
  assign w_start_go = (r_state == IDLE) && start;
  assign w_abort_go = (r_state != IDLE) && abort;
  assign w_used     = w_fifo_count + {1'b0, r_if_valid};

  // ---- FSM: state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---- FSM: next state ----
  // A start coinciding with the final transfer is not seen: state is still DRAIN.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start) w_next_state = RUN;
      RUN:     if (abort) w_next_state = IDLE;
               else if (rom_en && (r_rd_ptr == r_len_m1)) w_next_state = DRAIN;
      DRAIN:   if (abort || w_last_xfer) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // ---- FSM: outputs ----
  // Reads are credit-limited so the FIFO can always absorb every returning sample.
  always_comb begin
    busy   = (r_state != IDLE);
    rom_en = (r_state == RUN) && (w_used < 2'd2);
  end

  // ---- Output stream ----
  // The returning ROM word is presented directly when the FIFO is empty, so the
  // first beat appears the cycle the data returns. If it is not accepted it is
  // written to the FIFO and re-presented unchanged from there. m_valid depends
  // only on registers.
  always_comb begin
    w_fifo_empty     = (w_fifo_count == 2'd0);
    w_out_valid      = !w_fifo_empty || r_if_valid;
    w_rom_beat.data  = rom_data;
    w_rom_beat.index = r_if_idx;
    w_rom_beat.last  = r_if_last;
    if (!w_fifo_empty) begin
      w_out_beat = w_head;
    end else if (r_if_valid) begin
      w_out_beat = w_rom_beat;
    end else begin
      w_out_beat = '0;
    end
    w_xfer      = w_out_valid && m_if.m_ready;
    w_push      = r_if_valid && !(w_fifo_empty && m_if.m_ready);
    w_pop       = !w_fifo_empty && m_if.m_ready;
    w_last_xfer = w_xfer && w_out_beat.last;
  end

  ecg_stream_fifo u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (w_abort_go),
    .push    (w_push),
    .wr_beat (w_rom_beat),
    .pop     (w_pop),
    .rd_beat (w_head),
    .count   (w_fifo_count)
  );

  // ---- Read pointer, in-flight tracking, completion ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr    <= '0;
      r_len_m1    <= '0;
      r_if_valid  <= 1'b0;
      r_if_idx    <= '0;
      r_if_last   <= 1'b0;
      r_done      <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      if (w_start_go) begin
        r_rd_ptr <= '0;
        r_len_m1 <= w_len_eff - ADDR_W'(1);
      end else if (rom_en) begin
        r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      end
      // A read issued alongside abort is dropped on return.
      r_if_valid <= rom_en && !w_abort_go;
      if (rom_en) begin
        r_if_idx  <= r_rd_ptr;
        r_if_last <= (r_rd_ptr == r_len_m1);
      end
      r_done <= w_abort_go || w_last_xfer;
      if (w_last_xfer && !w_abort_go) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

  assign rom_addr       = r_rd_ptr;
  assign done           = r_done;
  assign frame_cnt      = r_frame_cnt;
  assign m_if.m_valid   = w_out_valid;
  assign m_if.m_data    = w_out_beat.data;
  assign m_if.m_index   = w_out_beat.index;
  assign m_if.m_last    = w_out_beat.last;

endmodule
`default_nettype wire

// File: tb/tb_ecg_sample_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_ecg_sample_sequencer                                         |
// | Purpose  : Self-checking bench for ecg_sample_sequencer. A ROM model feeds |
// |            the DUT; a queue of expected beats built from the ROM contents  |
// |            and the effective frame length checks every transfer.           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_ecg_sample_sequencer;

  typedef struct packed {
    logic [31:0] d;
    logic [7:0]  i;
    logic        l;
  } exp_beat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  len;
  logic        abort;
  logic        rom_en;
  logic [7:0]  rom_addr;
  logic [31:0] rom_data = 32'd0;
  logic        busy;
  logic        done;
  logic [15:0] frame_cnt;

  ecg_sample_sequencer_if ifc ();

  ecg_sample_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .abort     (abort),
    .rom_en    (rom_en),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .m_if      (ifc),
    .busy      (busy),
    .done      (done),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---- ROM model: registered read, data one cycle after rom_en ----
  logic [31:0] rom [256];
  always @(posedge clk) if (rom_en) rom_data <= rom[rom_addr];

  // ---- checking ----
  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    else n_pass++;
  endtask

  function automatic int eff_len(input int l);
    return (l == 0 || l > 187) ? 187 : l;
  endfunction

  // ---- reference model state ----
  exp_beat_t   q[$];
  int          issued, xferred, first_valid_cyc, last_cyc, exp_frames;
  logic [7:0]  exp_addr;
  logic        mon_en = 1'b0;
  logic        prev_stall;
  logic [63:0] prev_beat;

  task automatic model_start(input int l);
    int e;
    e = eff_len(l);
    q.delete();
    for (int i = 0; i < e; i++) q.push_back('{d: rom[i], i: 8'(i), l: (i == e - 1)});
    issued = 0; xferred = 0; exp_addr = 8'd0;
    first_valid_cyc = -1; last_cyc = -1; prev_stall = 1'b0;
    mon_en = 1'b1;
  endtask

  // ---- stream monitor ----
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if (prev_stall) begin
        check("stall_hold_valid", 64'(ifc.m_valid), 64'd1);
        check("stall_hold_beat", 64'({ifc.m_data, ifc.m_index, ifc.m_last}), prev_beat);
      end
      if (rom_en) begin
        check("credit_limit", 64'((issued - xferred) < 2), 64'd1);
        check("rom_addr_seq", 64'(rom_addr), 64'(exp_addr));
        exp_addr = exp_addr + 8'd1;
        issued++;
      end
      if (ifc.m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (ifc.m_valid && ifc.m_ready) begin
        if (q.size() == 0) begin
          check("beats_pending", 64'(q.size()), 64'd1);
        end else begin
          exp_beat_t e;
          e = q.pop_front();
          check("beat", 64'({ifc.m_data, ifc.m_index, ifc.m_last}), 64'(e));
        end
        xferred++;
        if (ifc.m_last) last_cyc = cyc;
      end
      prev_stall = ifc.m_valid && !ifc.m_ready;
      prev_beat  = 64'({ifc.m_data, ifc.m_index, ifc.m_last});
    end
  end

  // ---- consumer ready generation ----
  int         ready_mode = 0;  // 0: always, 1: 1,0,0,1 pattern, 2: random, 3: never
  int         ph = 0;
  logic [3:0] pat = 4'b1001;
  initial begin
    ifc.m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: ifc.m_ready = 1'b1;
        1: begin ifc.m_ready = pat[3 - ph]; ph = (ph + 1) % 4; end
        2: ifc.m_ready = 1'($urandom_range(0, 1));
        default: ifc.m_ready = 1'b0;
      endcase
    end
  end

  task automatic check_idle(input string p);
    check({p, "rom_en"},    64'(rom_en),      64'd0);
    check({p, "rom_addr"},  64'(rom_addr),    64'd0);
    check({p, "m_valid"},   64'(ifc.m_valid), 64'd0);
    check({p, "m_data"},    64'(ifc.m_data),  64'd0);
    check({p, "m_index"},   64'(ifc.m_index), 64'd0);
    check({p, "m_last"},    64'(ifc.m_last),  64'd0);
    check({p, "busy"},      64'(busy),        64'd0);
    check({p, "done"},      64'(done),        64'd0);
    check({p, "frame_cnt"}, 64'(frame_cnt),   64'd0);
  endtask

  // Called #1 after a posedge; returns at the negedge of cycle T+1.
  task automatic begin_frame(input int l, input bit with_abort, output int t);
    model_start(l);
    start = 1'b1; len = 8'(l); abort = with_abort; t = cyc;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("t1_busy",     64'(busy),     64'd1);
    check("t1_rom_en",   64'(rom_en),   64'd1);
    check("t1_rom_addr", 64'(rom_addr), 64'd0);
  endtask

  task automatic finish_frame(input int eff, input bit timing, input int t);
    int dcyc;
    dcyc = -1;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (done) begin dcyc = cyc; break; end
    end
    check("done_seen",     64'(dcyc >= 0), 64'd1);
    check("beat_count",    64'(xferred),   64'(eff));
    check("queue_drained", 64'(q.size()),  64'd0);
    if (timing) begin
      check("first_valid_lat", 64'(first_valid_cyc - t), 64'd2);
      check("last_beat_lat",   64'(last_cyc - t),        64'(eff + 1));
      check("done_lat",        64'(dcyc - t),            64'(eff + 2));
    end
    exp_frames++;
    check("frame_cnt", 64'(frame_cnt), 64'(exp_frames));
    @(negedge clk);
    check("done_one_cycle", 64'(done), 64'd0);
    check("idle_after",     64'(busy), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int l;
    bit found;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; len = 8'd0; exp_frames = 0;
    for (int i = 0; i < 256; i++) rom[i] = $urandom;
    rom[0]  = 32'h3F7F7CEE;
    rom[93] = 32'h00000000;
    rom[97] = 32'h3F800000;
    for (int i = 115; i < 187; i++) rom[i] = 32'h0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("rst_");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // short frame, full throughput
    ready_mode = 0;
    begin_frame(4, 1'b0, t);
    finish_frame(4, 1'b1, t);

    // len = 0 -> whole frame, no bubbles
    begin_frame(0, 1'b0, t);
    finish_frame(187, 1'b1, t);

    // ready toggling 1,0,0,1
    ready_mode = 1;
    begin_frame(8, 1'b0, t);
    finish_frame(8, 1'b0, t);

    // random lengths (including > N_SAMPLES) under random backpressure
    ready_mode = 2;
    repeat (3) begin
      l = int'($urandom_range(1, 255));
      begin_frame(l, 1'b0, t);
      finish_frame(eff_len(l), 1'b0, t);
    end

    // abort during RUN around idx 50
    ready_mode = 0; ifc.m_ready = 1'b1;
    begin_frame(0, 1'b0, t);
    found = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (rom_en && rom_addr == 8'd50) begin found = 1'b1; break; end
      @(negedge clk);
    end
    check("abort_point_reached", 64'(found), 64'd1);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    mon_en = 1'b0;
    @(negedge clk);
    check("abort_m_valid",   64'(ifc.m_valid), 64'd0);
    check("abort_done",      64'(done),        64'd1);
    check("abort_busy",      64'(busy),        64'd0);
    check("abort_rom_en",    64'(rom_en),      64'd0);
    check("abort_frame_cnt", 64'(frame_cnt),   64'(exp_frames));
    @(posedge clk); #1;
    begin_frame(2, 1'b0, t);
    finish_frame(2, 1'b1, t);

    // start while busy is ignored
    begin_frame(8, 1'b0, t);
    @(posedge clk); #1;
    start = 1'b1; len = 8'd3;
    @(posedge clk); #1;
    start = 1'b0;
    finish_frame(8, 1'b1, t);

    // start together with abort in IDLE: start wins
    begin_frame(3, 1'b1, t);
    finish_frame(3, 1'b1, t);

    // asynchronous reset mid-frame with a stalled beat on the bus
    ready_mode = 3; ifc.m_ready = 1'b0;
    begin_frame(0, 1'b0, t);
    repeat (4) @(negedge clk);
    check("pre_reset_valid", 64'(ifc.m_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    mon_en = 1'b0;
    #1;
    check_idle("arst_");
    @(posedge clk); #1;
    rst_n = 1'b1; exp_frames = 0; ready_mode = 0; ifc.m_ready = 1'b1;
    @(posedge clk); #1;
    begin_frame(5, 1'b0, t);
    finish_frame(5, 1'b1, t);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
